// File: rtl/sha256_pkg.sv
// Shared constants, FIFO entry layout and TX state for the SHA-256 digest transmitter.
// Define SHA256_TX_LEN_EN to append the 64-bit message bit length to every packet.
package sha256_pkg;

   localparam int unsigned DIGEST_BYTES = 32;
   localparam int unsigned LEN_BYTES    = 8;

`ifdef SHA256_TX_LEN_EN
   localparam int unsigned PKT_LAST = DIGEST_BYTES + LEN_BYTES - 1;
`else
   localparam int unsigned PKT_LAST = DIGEST_BYTES - 1;
`endif

   localparam int unsigned CNT_W = $clog2(PKT_LAST + 1);

   typedef struct packed {
      logic [31:0]  id;
`ifdef SHA256_TX_LEN_EN
      logic [60:0]  len;
`endif
      logic [255:0] sha;
   } entry_t;

   localparam int unsigned ENTRY_W = $bits(entry_t);

   typedef enum logic {StIdle, StSend} tx_state_t;

   // Byte n of the packet, most significant byte first.
   function automatic logic [7:0] pkt_byte(entry_t e, logic [CNT_W-1:0] n);
      logic [255:0] s;
`ifdef SHA256_TX_LEN_EN
      logic [63:0]  l;
      l = {e.len, 3'b000} << {n[2:0], 3'b000};
      if (n >= CNT_W'(DIGEST_BYTES)) return l[63:56];
`endif
      s = e.sha << {n[4:0], 3'b000};
      return s[255:248];
   endfunction

endpackage

// File: rtl/sha256_digest_fifo.sv
// Synchronous digest FIFO; exposes both the head and the entry behind it so the
// transmitter can start the next packet without a bubble.
module sha256_digest_fifo
   import sha256_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [ENTRY_W-1:0]       wdata,
   output logic [ENTRY_W-1:0]       head,
   output logic [ENTRY_W-1:0]       next,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wptr_q, rptr_q;
   logic               do_push, do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot being written.
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rptr_q];
   assign next    = mem[rptr_q + AW'(1)];

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         level  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   end

endmodule

// File: rtl/sha256_digest_tx.sv
// Buffers SHA-256 results and streams each digest as a big-endian byte packet.
// Define SHA256_TX_LEN_EN to append the bit length after the digest.
module sha256_digest_tx
   import sha256_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ivalid,
   input  logic [31:0]              iid,
   input  logic [60:0]              ilen,
   input  logic [255:0]             isha,
   input  logic                     tready,
   output logic                     tvalid,
   output logic                     tlast,
   output logic [31:0]              tid,
   output logic [7:0]               tdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;

   entry_t             wentry, head_e, next_e;
   logic [ENTRY_W-1:0] head, next;
   logic               full, empty, pop;
   tx_state_t          state;
   logic [CNT_W-1:0]   cnt, cnt_nxt;

`ifdef SHA256_TX_LEN_EN
   always_comb begin
      wentry     = '0;
      wentry.id  = iid;
      wentry.len = ilen;
      wentry.sha = isha;
   end
`else
   logic unused_ilen;
   assign unused_ilen = ^ilen;

   always_comb begin
      wentry     = '0;
      wentry.id  = iid;
      wentry.sha = isha;
   end
`endif

   assign head_e  = entry_t'(head);
   assign next_e  = entry_t'(next);
   assign cnt_nxt = cnt + CNT_W'(1);
   assign pop     = (state == StSend) & tvalid & tready & tlast;

   sha256_digest_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ivalid),
      .pop   (pop),
      .wdata (wentry),
      .head  (head),
      .next  (next),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= StIdle;
         cnt      <= '0;
         tvalid   <= 1'b0;
         tlast    <= 1'b0;
         tid      <= '0;
         tdata    <= '0;
         overflow <= 1'b0;
      end else begin
         if (ivalid & full & ~pop) overflow <= 1'b1;
         case (state)
            StIdle: begin
               if (!empty) begin
                  state  <= StSend;
                  cnt    <= '0;
                  tvalid <= 1'b1;
                  tlast  <= 1'b0;
                  tid    <= head_e.id;
                  tdata  <= pkt_byte(head_e, '0);
               end
            end
            StSend: begin
               if (tready) begin
                  if (tlast) begin
                     // The entry behind the popped head is already stored; chain directly.
                     if (level > LW'(1)) begin
                        cnt   <= '0;
                        tlast <= 1'b0;
                        tid   <= next_e.id;
                        tdata <= pkt_byte(next_e, '0);
                     end else begin
                        state  <= StIdle;
                        tvalid <= 1'b0;
                        tlast  <= 1'b0;
                     end
                  end else begin
                     cnt   <= cnt_nxt;
                     tlast <= (cnt_nxt == CNT_W'(PKT_LAST));
                     tdata <= pkt_byte(head_e, cnt_nxt);
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_digest_tx.sv
// Randomized self-checking bench for sha256_digest_tx against a byte-queue reference model.
module tb_sha256_digest_tx;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;
`ifdef SHA256_TX_LEN_EN
   localparam int PKT = 40;
`else
   localparam int PKT = 32;
`endif
   localparam logic [255:0] ABC =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ivalid = 1'b0;
   logic [31:0]   iid = '0;
   logic [60:0]   ilen = '0;
   logic [255:0]  isha = '0;
   logic          tready = 1'b0;
   logic          tvalid, tlast, overflow;
   logic [31:0]   tid;
   logic [7:0]    tdata;
   logic [LW-1:0] level;

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_b[$];
   logic [31:0] exp_id[$];
   logic        exp_last[$];

   always #5 clk = ~clk;

   sha256_digest_tx #(
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ivalid   (ivalid),
      .iid      (iid),
      .ilen     (ilen),
      .isha     (isha),
      .tready   (tready),
      .tvalid   (tvalid),
      .tlast    (tlast),
      .tid      (tid),
      .tdata    (tdata),
      .level    (level),
      .overflow (overflow)
   );

   // Reference model: expected packet bytes appended in arrival order.
   function automatic void model_push(logic [31:0] id, logic [60:0] len, logic [255:0] sha);
      logic [63:0] bits;
      bits = {len, 3'b000};
      for (int n = 0; n < PKT; n++) begin
         if (n < 32) exp_b.push_back(sha[255 - 8 * n -: 8]);
         else exp_b.push_back(bits[63 - 8 * (n - 32) -: 8]);
         exp_id.push_back(id);
         exp_last.push_back(n == PKT - 1);
      end
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32 * i +: 32] = $urandom();
      return r;
   endfunction

   task automatic push(input logic [31:0] id, input logic [60:0] len, input logic [255:0] sha,
                       input bit keep);
      @(posedge clk);
      #1;
      ivalid = 1'b1;
      iid    = id;
      ilen   = len;
      isha   = sha;
      if (keep) model_push(id, len, sha);
   endtask

   task automatic push_end();
      @(posedge clk);
      #1;
      ivalid = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst    = 1'b1;
      ivalid = 1'b0;
      tready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_b.delete();
      exp_id.delete();
      exp_last.delete();
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({tvalid, tlast, tid, tdata, level, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_values: got v%b l%b id%h d%h lvl%0d ov%b want all 0",
                  tvalid, tlast, tid, tdata, level, overflow);
      end
      rst = 1'b0;
   endtask

   task automatic test_abc();
      int c;
      @(posedge clk);
      #1;
      ivalid = 1'b1;
      iid    = 32'd7;
      ilen   = 61'd3;
      isha   = ABC;
      tready = 1'b1;
      model_push(32'd7, 61'd3, ABC);
      @(posedge clk);
      #1;
      ivalid = 1'b0;
      @(negedge clk);
      checks++;
      if (level !== LW'(1) || tvalid !== 1'b0) begin
         errors++;
         $display("FAIL abc_n1: got level %0d tvalid %b want 1 0", level, tvalid);
      end
      for (c = 0; c < PKT + 10 && exp_b.size() != 0; c++) begin
         @(negedge clk);
         if (c == 0) begin
            checks++;
            if (tvalid !== 1'b1) begin
               errors++;
               $display("FAIL abc_latency: got tvalid %b want 1 at N+2", tvalid);
            end
         end
         if (tvalid && tready) begin
            checks++;
            if ({tdata, tid, tlast} !== {exp_b[0], exp_id[0], exp_last[0]}) begin
               errors++;
               $display("FAIL abc_byte: got %h/%h/%b want %h/%h/%b", tdata, tid, tlast,
                        exp_b[0], exp_id[0], exp_last[0]);
            end
            void'(exp_b.pop_front());
            void'(exp_id.pop_front());
            void'(exp_last.pop_front());
         end
      end
      @(negedge clk);
      checks++;
      if (exp_b.size() != 0 || tvalid !== 1'b0 || level !== '0) begin
         errors++;
         $display("FAIL abc_end: got left %0d tvalid %b level %0d want 0 0 0",
                  exp_b.size(), tvalid, level);
      end
   endtask

   task automatic test_backpressure();
      logic [41:0] prev;
      bit          stalled;
      stalled = 1'b0;
      prev    = '0;
      apply_reset();
      push(32'd7, 61'd3, ABC, 1'b1);
      push_end();
      for (int c = 0; c < PKT * 10 && exp_b.size() != 0; c++) begin
         @(negedge clk);
         if (stalled) begin
            checks++;
            if ({tvalid, tlast, tid, tdata} !== prev) begin
               errors++;
               $display("FAIL bp_stable: got %h want %h", {tvalid, tlast, tid, tdata}, prev);
            end
         end
         if (tvalid && tready) begin
            checks++;
            if ({tdata, tid, tlast} !== {exp_b[0], exp_id[0], exp_last[0]}) begin
               errors++;
               $display("FAIL bp_byte: got %h/%h/%b want %h/%h/%b", tdata, tid, tlast,
                        exp_b[0], exp_id[0], exp_last[0]);
            end
            void'(exp_b.pop_front());
            void'(exp_id.pop_front());
            void'(exp_last.pop_front());
         end
         stalled = tvalid && !tready;
         prev    = {tvalid, tlast, tid, tdata};
         @(posedge clk);
         #1;
         tready = 1'($urandom_range(0, 1));
      end
      checks++;
      if (exp_b.size() != 0) begin
         errors++;
         $display("FAIL bp_timeout: got %0d bytes left want 0", exp_b.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [255:0] s [3];
      bit           started;
      started = 1'b0;
      apply_reset();
      tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s[i] = rand256();
         model_push(32'(i + 1), 61'($urandom()), s[i]);
      end
      fork
         begin
            for (int i = 0; i < 3; i++) push(32'(i + 1), 61'd0, s[i], 1'b0);
            push_end();
         end
         begin
            for (int c = 0; c < 3 * PKT + 20 && exp_b.size() != 0; c++) begin
               @(negedge clk);
               if (started) begin
                  checks++;
                  if (tvalid !== 1'b1) begin
                     errors++;
                     $display("FAIL b2b_gap: got tvalid %b want 1 with %0d bytes left",
                              tvalid, exp_b.size());
                  end
               end
               if (tvalid && tready) begin
                  started = 1'b1;
                  checks++;
                  if ({tdata, tid, tlast} !== {exp_b[0], exp_id[0], exp_last[0]}) begin
                     errors++;
                     $display("FAIL b2b_byte: got %h/%h/%b want %h/%h/%b", tdata, tid, tlast,
                              exp_b[0], exp_id[0], exp_last[0]);
                  end
                  void'(exp_b.pop_front());
                  void'(exp_id.pop_front());
                  void'(exp_last.pop_front());
               end
            end
         end
      join
      checks++;
      if (exp_b.size() != 0) begin
         errors++;
         $display("FAIL b2b_timeout: got %0d bytes left want 0", exp_b.size());
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int i = 0; i <= DEPTH; i++) begin
         push(32'h100 + 32'(i), 61'(i + 1), rand256(), i < DEPTH);
         @(negedge clk);
         if (i == DEPTH) begin
            checks++;
            if (overflow !== 1'b0) begin
               errors++;
               $display("FAIL ovf_early: got overflow %b want 0", overflow);
            end
         end
      end
      push_end();
      @(negedge clk);
      checks++;
      if (level !== LW'(DEPTH) || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_full: got level %0d overflow %b want %0d 1", level, overflow, DEPTH);
      end
      @(posedge clk);
      #1;
      tready = 1'b1;
      for (int c = 0; c < DEPTH * PKT + 20 && exp_b.size() != 0; c++) begin
         @(negedge clk);
         if (tvalid && tready) begin
            checks++;
            if ({tdata, tid, tlast} !== {exp_b[0], exp_id[0], exp_last[0]}) begin
               errors++;
               $display("FAIL ovf_byte: got %h/%h/%b want %h/%h/%b", tdata, tid, tlast,
                        exp_b[0], exp_id[0], exp_last[0]);
            end
            void'(exp_b.pop_front());
            void'(exp_id.pop_front());
            void'(exp_last.pop_front());
         end
      end
      repeat (5) @(negedge clk);
      checks++;
      if (exp_b.size() != 0 || tvalid !== 1'b0 || level !== '0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_drain: got left %0d tvalid %b level %0d ov %b want 0 0 0 1",
                  exp_b.size(), tvalid, level, overflow);
      end
   endtask

   task automatic test_push_on_pop_full();
      int inj;
      inj = 0;
      apply_reset();
      for (int i = 0; i < DEPTH; i++) push(32'h200 + 32'(i), 61'(i), rand256(), 1'b1);
      push_end();
      @(negedge clk);
      checks++;
      if (level !== LW'(DEPTH)) begin
         errors++;
         $display("FAIL pop_full_pre: got level %0d want %0d", level, DEPTH);
      end
      @(posedge clk);
      #1;
      tready = 1'b1;
      for (int c = 0; c < (DEPTH + 1) * PKT + 20 && exp_b.size() != 0; c++) begin
         @(negedge clk);
         if (inj == 1) begin
            inj = 2;
            checks++;
            if (level !== LW'(DEPTH) || overflow !== 1'b0) begin
               errors++;
               $display("FAIL pop_full_push: got level %0d ov %b want %0d 0",
                        level, overflow, DEPTH);
            end
         end
         if (tvalid && tready) begin
            checks++;
            if ({tdata, tid, tlast} !== {exp_b[0], exp_id[0], exp_last[0]}) begin
               errors++;
               $display("FAIL pop_full_byte: got %h/%h/%b want %h/%h/%b", tdata, tid, tlast,
                        exp_b[0], exp_id[0], exp_last[0]);
            end
            if (tlast && inj == 0) begin
               inj    = 1;
               ivalid = 1'b1;
               iid    = 32'h2ff;
               ilen   = 61'd55;
               isha   = rand256();
               model_push(iid, ilen, isha);
            end
            void'(exp_b.pop_front());
            void'(exp_id.pop_front());
            void'(exp_last.pop_front());
         end
         @(posedge clk);
         #1;
         ivalid = 1'b0;
      end
      checks++;
      if (exp_b.size() != 0 || inj != 2) begin
         errors++;
         $display("FAIL pop_full_timeout: got left %0d stage %0d want 0 2", exp_b.size(), inj);
      end
   endtask

   task automatic test_reset_mid_packet();
      int k;
      bit done;
      k    = 0;
      done = 1'b0;
      apply_reset();
      tready = 1'b1;
      push(32'h33, 61'd9, rand256(), 1'b1);
      push_end();
      for (int c = 0; c < PKT + 10 && !done; c++) begin
         @(negedge clk);
         if (tvalid && k == 10) begin
            rst = 1'b1;
            #1;
            done = 1'b1;
            checks++;
            if ({tvalid, tlast, tid, tdata, level, overflow} !== '0) begin
               errors++;
               $display("FAIL rst_mid: got v%b l%b id%h d%h lvl%0d ov%b want all 0",
                        tvalid, tlast, tid, tdata, level, overflow);
            end
         end else if (tvalid && tready) begin
            checks++;
            if ({tdata, tid, tlast} !== {exp_b[0], exp_id[0], exp_last[0]}) begin
               errors++;
               $display("FAIL rst_pre_byte: got %h/%h/%b want %h/%h/%b", tdata, tid, tlast,
                        exp_b[0], exp_id[0], exp_last[0]);
            end
            void'(exp_b.pop_front());
            void'(exp_id.pop_front());
            void'(exp_last.pop_front());
            k++;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL rst_mid_timeout: got %0d bytes want 10", k);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_b.delete();
      exp_id.delete();
      exp_last.delete();
      push(32'h44, 61'd1000, rand256(), 1'b1);
      push_end();
      for (int c = 0; c < PKT + 10 && exp_b.size() != 0; c++) begin
         @(negedge clk);
         if (tvalid && tready) begin
            checks++;
            if ({tdata, tid, tlast} !== {exp_b[0], exp_id[0], exp_last[0]}) begin
               errors++;
               $display("FAIL rst_post_byte: got %h/%h/%b want %h/%h/%b", tdata, tid, tlast,
                        exp_b[0], exp_id[0], exp_last[0]);
            end
            void'(exp_b.pop_front());
            void'(exp_id.pop_front());
            void'(exp_last.pop_front());
         end
      end
      checks++;
      if (exp_b.size() != 0) begin
         errors++;
         $display("FAIL rst_post_timeout: got %0d bytes left want 0", exp_b.size());
      end
   endtask

   initial begin
      test_reset();
      test_abc();
      test_backpressure();
      test_back_to_back();
      test_overflow();
      test_push_on_pop_full();
      test_reset_mid_packet();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
